// File: rtl/pipeline_swap_sequencer.sv
// Sequences a click-free A/B pipeline swap. The output gain ramps down to
// zero, the active pipeline flips, the gain holds at zero for a settle
// period, and then ramps back up to unity. After that the pipeline that is
// now inactive gets a one-cycle clear pulse.
//
// Ports:
//   clk                   system clock
//   reset                 synchronous, active-high reset
//   i_swap_req            one-cycle swap request from the command controller
//   i_sample_tick         one-cycle pulse per audio sample
//   o_active_pipeline     selects the pipeline that feeds the output
//   o_pipelines_swapping  high while a swap is in progress
//   o_mix_gain            output mix gain (unity = 2^(DATA_WIDTH-1))
//   o_reset_pipeline      one-cycle clear pulse, indexed by pipeline
//   o_swap_done           one-cycle pulse when a swap completes
module pipeline_swap_sequencer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned RAMP_LOG2      = 6,
  parameter int unsigned SETTLE_SAMPLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_swap_req,
  input  logic                  i_sample_tick,
  output logic                  o_active_pipeline,
  output logic                  o_pipelines_swapping,
  output logic [DATA_WIDTH-1:0] o_mix_gain,
  output logic [1:0]            o_reset_pipeline,
  output logic                  o_swap_done
);

  localparam logic [DATA_WIDTH-1:0] UNITY = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] STEP  = UNITY >> RAMP_LOG2;
  localparam int unsigned CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_OUT,
    S_SWITCH,
    S_SETTLE,
    S_FADE_IN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_pending;
  logic [CNT_W-1:0]      r_settle_cnt;
  logic                  r_active;
  logic                  r_swapping;
  logic [DATA_WIDTH-1:0] r_gain;
  logic [1:0]            r_reset_pipeline;
  logic                  r_swap_done;

  logic [DATA_WIDTH:0]   w_gain_dn;
  logic [DATA_WIDTH:0]   w_gain_up;
  logic [DATA_WIDTH-1:0] w_gain_dn_sat;
  logic [DATA_WIDTH-1:0] w_gain_up_sat;

  // Ramp arithmetic is one bit wider so that both underflow and overshoot
  // are visible before saturation.
  assign w_gain_dn     = {1'b0, r_gain} - {1'b0, STEP};
  assign w_gain_up     = {1'b0, r_gain} + {1'b0, STEP};
  assign w_gain_dn_sat = w_gain_dn[DATA_WIDTH] ? '0 : w_gain_dn[DATA_WIDTH-1:0];
  assign w_gain_up_sat = (w_gain_up >= {1'b0, UNITY}) ? UNITY : w_gain_up[DATA_WIDTH-1:0];

  // Swap sequencer. Every output is a register, and each one is updated on
  // the transition so that it lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_pending        <= 1'b0;
      r_settle_cnt     <= '0;
      r_active         <= 1'b0;
      r_swapping       <= 1'b0;
      r_gain           <= UNITY;
      r_reset_pipeline <= 2'b00;
      r_swap_done      <= 1'b0;
    end else begin
      r_reset_pipeline <= 2'b00;
      r_swap_done      <= 1'b0;

      // One-deep request queue. A request that arrives while one is already
      // queued is dropped.
      if (i_swap_req && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_swap_req || r_pending) begin
            r_state    <= S_FADE_OUT;
            r_swapping <= 1'b1;
            r_pending  <= 1'b0;
          end
        end
        S_FADE_OUT: begin
          if (i_sample_tick) begin
            r_gain <= w_gain_dn_sat;
            if (w_gain_dn_sat == '0) begin
              r_state <= S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          r_active     <= ~r_active;
          r_settle_cnt <= CNT_W'(SETTLE_SAMPLES);
          r_state      <= (SETTLE_SAMPLES == 0) ? S_FADE_IN : S_SETTLE;
        end
        S_SETTLE: begin
          if (i_sample_tick) begin
            r_settle_cnt <= r_settle_cnt - CNT_W'(1);
            if (r_settle_cnt == CNT_W'(1)) begin
              r_state <= S_FADE_IN;
            end
          end
        end
        S_FADE_IN: begin
          if (i_sample_tick) begin
            r_gain <= w_gain_up_sat;
            if (w_gain_up_sat == UNITY) begin
              // The pulses are visible during DONE. The pipeline that gets
              // cleared is the one that has just been switched out.
              r_state          <= S_DONE;
              r_swap_done      <= 1'b1;
              r_reset_pipeline <= r_active ? 2'b01 : 2'b10;
            end
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_swapping <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_swapping <= 1'b0;
        end
      endcase
    end
  end

  assign o_active_pipeline    = r_active;
  assign o_pipelines_swapping = r_swapping;
  assign o_mix_gain           = r_gain;
  assign o_reset_pipeline     = r_reset_pipeline;
  assign o_swap_done          = r_swap_done;

endmodule

// File: tb/tb_pipeline_swap_sequencer.sv
// Bench for pipeline_swap_sequencer. It checks the default configuration
// every cycle against a tick-count reference model. It also runs a short
// directed sequence on a second instance with an instant ramp and no settle.
module tb_pipeline_swap_sequencer;

  localparam int N     = 64;       // ramp ticks each way at default
  localparam int S     = 4;        // settle ticks at default
  localparam int UNITY = 32768;
  localparam int STEP  = UNITY / N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, tick0, req1, tick1;
  logic        o0_active, o0_swapping, o0_done;
  logic [15:0] o0_gain;
  logic [1:0]  o0_rp;
  logic        o1_active, o1_swapping, o1_done;
  logic [15:0] o1_gain;
  logic [1:0]  o1_rp;

  pipeline_swap_sequencer dut0 (
    .clk(clk), .reset(reset), .i_swap_req(req0), .i_sample_tick(tick0),
    .o_active_pipeline(o0_active), .o_pipelines_swapping(o0_swapping),
    .o_mix_gain(o0_gain), .o_reset_pipeline(o0_rp), .o_swap_done(o0_done)
  );

  pipeline_swap_sequencer #(.DATA_WIDTH(16), .RAMP_LOG2(0), .SETTLE_SAMPLES(0)) dut1 (
    .clk(clk), .reset(reset), .i_swap_req(req1), .i_sample_tick(tick1),
    .o_active_pipeline(o1_active), .o_pipelines_swapping(o1_swapping),
    .o_mix_gain(o1_gain), .o_reset_pipeline(o1_rp), .o_swap_done(o1_done)
  );

  int n_checks;
  int n_fail;
  int done_seen;

  // Reference model. A swap is described by how many sample ticks it has
  // consumed. Ticks 1..N are the fade out. One idle switch cycle follows
  // them. Ticks N+1..N+S are the settle, and the remaining N ticks are the
  // fade in. The completion cycle comes after the last tick.
  bit m_busy, m_done, m_pend, m_switched, m_active;
  int m_k;

  function automatic int exp_gain();
    if (!m_busy)      return UNITY;
    if (m_k <= N)     return UNITY - m_k * STEP;
    if (m_k <= N + S) return 0;
    return (m_k - N - S) * STEP;
  endfunction

  task automatic model_edge(input bit rst, input bit req, input bit tick);
    if (rst) begin
      m_busy = 0; m_done = 0; m_pend = 0; m_switched = 0; m_active = 0; m_k = 0;
    end else if (!m_busy) begin
      if (req || m_pend) begin
        m_busy = 1; m_k = 0; m_switched = 0; m_pend = 0;
      end
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
      if (req) m_pend = 1;
    end else begin
      if (req) m_pend = 1;
      if (m_k == N && !m_switched) begin
        m_switched = 1;
        m_active   = !m_active;
      end else if (tick) begin
        m_k++;
        if (m_k == 2 * N + S) m_done = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of dut0, checked against the model afterwards.
  task automatic step(input bit rst, input bit req, input bit tick);
    reset = rst; req0 = req; tick0 = tick; req1 = 1'b0; tick1 = 1'b0;
    @(posedge clk);
    model_edge(rst, req, tick);
    #1;
    if (o0_done === 1'b1) done_seen++;
    chk("active", 32'(o0_active), 32'(m_active));
    chk("swapping", 32'(o0_swapping), 32'(m_busy));
    chk("gain", 32'(o0_gain), 32'(exp_gain()));
    chk("reset_pipeline", 32'(o0_rp), m_done ? (m_active ? 32'd1 : 32'd2) : 32'd0);
    chk("swap_done", 32'(o0_done), 32'(m_done));
  endtask

  // One clock of dut1. The caller checks its outputs.
  task automatic step1(input bit req, input bit tick);
    reset = 1'b0; req0 = 1'b0; tick0 = 1'b0; req1 = req; tick1 = tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    n_checks = 0; n_fail = 0; done_seen = 0;
    reset = 1'b1; req0 = 1'b0; tick0 = 1'b0; req1 = 1'b0; tick1 = 1'b0;
    m_busy = 0; m_done = 0; m_pend = 0; m_switched = 0; m_active = 0; m_k = 0;

    // Reset, then stay idle while sample ticks keep arriving.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

    // A single swap with a tick every 8 cycles.
    done_seen = 0;
    step(1'b0, 1'b1, 1'b0);
    c = 0;
    while ((m_busy || m_pend) && c < 3000) begin
      step(1'b0, 1'b0, (c % 8) == 7);
      c++;
    end
    chk("swap1_timeout", 32'(c < 3000), 32'd1);
    chk("swap1_done_count", 32'(done_seen), 32'd1);
    chk("swap1_active", 32'(o0_active), 32'd1);

    // Reset while the sequencer is settling.
    step(1'b0, 1'b1, 1'b0);
    c = 0;
    while (!(m_switched && m_k == N + 2) && c < 3000) begin
      step(1'b0, 1'b0, (c % 5) == 4);
      c++;
    end
    chk("settle_reached", 32'(c < 3000), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_settle_active", 32'(o0_active), 32'd0);
    chk("rst_settle_gain", 32'(o0_gain), 32'h8000);
    chk("rst_settle_swapping", 32'(o0_swapping), 32'd0);
    chk("rst_settle_rp", 32'(o0_rp), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // A swap, then three more requests during the fade. Two swaps result.
    done_seen = 0;
    step(1'b0, 1'b1, 1'b0);
    c = 0;
    while ((c < 60 || m_busy || m_pend) && c < 6000) begin
      step(1'b0, (c == 20) || (c == 30) || (c == 40), (c % 4) == 3);
      c++;
    end
    chk("b2b_timeout", 32'(c < 6000), 32'd1);
    chk("b2b_done_count", 32'(done_seen), 32'd2);
    chk("b2b_active", 32'(o0_active), 32'd0);

    // Random requests, ticks and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 999) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 2) == 0);
    end

    // Instant ramp with no settle phase.
    step1(1'b0, 1'b0);
    chk("d1_idle_gain", 32'(o1_gain), 32'h8000);
    chk("d1_idle_swapping", 32'(o1_swapping), 32'd0);
    step1(1'b1, 1'b1);
    chk("d1_req_swapping", 32'(o1_swapping), 32'd1);
    chk("d1_req_tick_ignored", 32'(o1_gain), 32'h8000);
    step1(1'b0, 1'b1);
    chk("d1_tick1_gain", 32'(o1_gain), 32'd0);
    chk("d1_tick1_active", 32'(o1_active), 32'd0);
    step1(1'b0, 1'b0);
    chk("d1_switch_active", 32'(o1_active), 32'd1);
    chk("d1_switch_gain", 32'(o1_gain), 32'd0);
    step1(1'b0, 1'b1);
    chk("d1_tick2_gain", 32'(o1_gain), 32'h8000);
    chk("d1_done_pulse", 32'(o1_done), 32'd1);
    chk("d1_done_rp", 32'(o1_rp), 32'd1);
    chk("d1_done_swapping", 32'(o1_swapping), 32'd1);
    step1(1'b0, 1'b0);
    chk("d1_idle2_swapping", 32'(o1_swapping), 32'd0);
    chk("d1_idle2_done", 32'(o1_done), 32'd0);
    chk("d1_idle2_rp", 32'(o1_rp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
